i2c_wb_sequencer: RTL and testbench
===================================

// Module: i2c_wb_sequencer
// PURPOSE
//  Command-level front end for the Wishbone I2C master core. Accepts one register transaction
//  (7-bit device, 8-bit register, write or read one byte), drives the core's 8-bit Wishbone slave
//  port (PRER/CTR/TXR/RXR/CR/SR) and polls status until done. Returns read data and an error code.
//  Sits directly upstream of the I2C core wrapper; CPU/init logic issues commands here.
// PARAMETERS
//  PRESCALE      16'd99   value written to PRERhi:PRERlo at init (clk/(5*f_scl)-1; 50 MHz -> 100 kHz)
//  POLL_TIMEOUT  20'd1000000  max cycles polling TIP per byte before abort
// PORTS
//  wb_clk_i      in   1  clock
//  wb_rst_i      in   1  reset, asynchronous, active-high
//  cmd_valid_i   in   1  command request
//  cmd_ready_o   out  1  sequencer idle and initialised; command accepted when valid&ready
//  cmd_rd_i      in   1  1=read, 0=write
//  cmd_dev_i     in   7  I2C device address
//  cmd_reg_i     in   8  device register address
//  cmd_wdata_i   in   8  write data
//  rsp_valid_o   out  1  one-cycle pulse: transaction finished
//  rsp_rdata_o   out  8  read byte (valid with rsp_valid_o, read only; held until next rsp)
//  rsp_err_o     out  2  0 ok, 1 NACK, 2 arbitration lost, 3 timeout
//  wbm_adr_o     out  3  core register address
//  wbm_dat_o     out  8  write data to core
//  wbm_dat_i     in   8  read data from core
//  wbm_we_o      out  1  write enable
//  wbm_stb_o     out  1  strobe (core's cyc is tied to stb)
//  wbm_ack_i     in   1  acknowledge from core
// BEHAVIOUR
//  Reset: all outputs 0; state INIT, step 0. Reset mid-transaction drops stb immediately, no STOP.
//  Bus access: set adr/dat/we, raise stb; hold all stable until ack; drop stb in the cycle after ack
//   sample (stb low >=1 cycle between accesses). Read data captured on the ack cycle.
//  INIT: write adr0=PRESCALE[7:0], adr1=PRESCALE[15:8], adr2=0x80 (EN); then IDLE.
//  IDLE: cmd_ready_o=1; on accept latch cmd fields, ready drops next cycle.
//  Byte step = write TXR (adr3), write CR (adr4), then POLL: read SR repeatedly until TIP(bit1)=0.
//   After TIP=0: AL(bit5)=1 -> err 2, go RESP (no STOP). RxACK(bit7)=1 on a WR step -> err 1, STOP.
//  Write sequence: TXR={dev,0}/CR=0x90; TXR=reg/CR=0x10; TXR=wdata/CR=0x50 (STO|WR).
//  Read sequence: TXR={dev,0}/CR=0x90; TXR=reg/CR=0x10; TXR={dev,1}/CR=0x90 (repeated start);
//   CR=0x68 (RD|ACK(nack)|STO, no TXR write), poll, read adr3 -> rsp_rdata_o. RxACK ignored on RD step.
//  STOP (error path): write CR=0x40, poll TIP, then RESP with latched error.
//  Timeout: counter cleared at each POLL entry, incremented per cycle; reaching POLL_TIMEOUT
//   -> err 3, write CR=0x40 (no further poll), RESP. STOP poll also subject to timeout (err kept).
//  RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. cmd_valid_i ignored outside IDLE.
//  Error priority if simultaneous: AL > NACK. Counter width 20 bits, saturates never (aborts first).
// STRUCTURE
//  Shared defines file i2c_seq_defines.v: register addresses (PRERLO..CR/SR), CR bits STA/STO/RD/WR/
//   ACK/IACK, SR bits RXACK/BUSY/AL/TIP/IF, error codes, state encodings.
//  Sub-module i2c_wbm_port: single-access Wishbone master (req/we/adr/dat in, done/rdata out).
//  Top: main FSM INIT/IDLE/TXR/CR/POLL/STOP/RDRX/RESP plus byte-step counter and timeout counter.
// TESTING (bench: this block + I2C core + I2C slave model at dev 0x50)
//  Reset release -> wbm writes 0x63@0, 0x00@1, 0x80@2, then cmd_ready_o=1.
//  Write dev 0x50 reg 0x12 data 0xA5 -> bus sees A0,12,A5 + STOP; rsp_err 0; slave reg 0x12=0xA5.
//  Read dev 0x50 reg 0x12 -> A0,12, Sr, A1, byte NACKed, STOP; rsp_rdata 0xA5, err 0.
//  Write to absent dev 0x33 -> NACK on address; CR=0x40 issued; rsp_err 1; bus idle after.
//  Slave model stretches SCL forever, POLL_TIMEOUT=500 -> rsp_err 3 within ~500 cycles of CR write.
//  Assert wb_rst_i during data byte -> stb 0 same cycle, outputs 0; after release INIT re-runs.

Source files
------------

// File: rtl/i2c_wb_sequencer_pkg.sv
// Shared constants for the I2C command sequencer: core register map, CR/SR bits,
// error codes, FSM states and the per-step command byte helper.
package i2c_wb_sequencer_pkg;

  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;  // RXR on read
  localparam logic [2:0] ADR_CR     = 3'd4;  // SR on read

  localparam logic [7:0] CTR_EN  = 8'h80;
  localparam logic [7:0] CR_STA  = 8'h80;
  localparam logic [7:0] CR_STO  = 8'h40;
  localparam logic [7:0] CR_RD   = 8'h20;
  localparam logic [7:0] CR_WR   = 8'h10;
  localparam logic [7:0] CR_ACK  = 8'h08;
  localparam logic [7:0] CR_IACK = 8'h01;

  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;
  localparam int SR_IF    = 0;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_AL   = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_TXR, S_CR, S_POLL, S_STOP, S_RDRX, S_RESP
  } state_t;

  // Step 2 of a read is the repeated start; step 3 receives the byte and NACKs it.
  function automatic logic [7:0] cr_cmd(input logic [1:0] step, input logic rd);
    unique case (step)
      2'd0:    cr_cmd = CR_STA | CR_WR;
      2'd1:    cr_cmd = CR_WR;
      2'd2:    cr_cmd = rd ? (CR_STA | CR_WR) : (CR_STO | CR_WR);
      default: cr_cmd = CR_RD | CR_ACK | CR_STO;
    endcase
  endfunction

endpackage

// File: rtl/i2c_wb_sequencer_if.sv
// Command/response channel and 8-bit Wishbone master channel of the sequencer.
interface i2c_cmd_if;
  logic       cmd_valid, cmd_ready, cmd_rd;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  modport master (output cmd_valid, cmd_rd, cmd_dev, cmd_reg, cmd_wdata,
                  input  cmd_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  cmd_valid, cmd_rd, cmd_dev, cmd_reg, cmd_wdata,
                  output cmd_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface i2c_wb_if;
  logic [2:0] adr;
  logic [7:0] wdat, rdat;
  logic       we, stb, ack;
  modport master (output adr, wdat, we, stb, input rdat, ack);
  modport slave  (input adr, wdat, we, stb, output rdat, ack);
endinterface

// File: rtl/i2c_wbm_port.sv
// Single-access Wishbone master: launches one access per req, holds it until ack,
// and always leaves stb low for at least one cycle between accesses.
module i2c_wbm_port (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] wdat,
  output logic       done,
  output logic       busy,
  output logic [7:0] rdata,
  i2c_wb_if.master   bus
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stb  <= 1'b0;
      bus.we   <= 1'b0;
      bus.adr  <= 3'd0;
      bus.wdat <= 8'h00;
    end else if (bus.stb) begin
      if (bus.ack) bus.stb <= 1'b0;
    end else if (req) begin
      bus.stb  <= 1'b1;
      bus.we   <= we;
      bus.adr  <= adr;
      bus.wdat <= wdat;
    end
  end

  assign done  = bus.stb & bus.ack;
  assign busy  = bus.stb;
  assign rdata = bus.rdat;
endmodule

// File: rtl/i2c_wb_sequencer.sv
// Command-level front end for the Wishbone I2C master core: one register write or
// read per command, status polling with timeout, STOP on NACK/timeout.
module i2c_wb_sequencer
  import i2c_wb_sequencer_pkg::*;
#(
  parameter logic [15:0] PRESCALE     = 16'd99,
  parameter logic [19:0] POLL_TIMEOUT = 20'd1000000
) (
  input  logic      wb_clk_i,
  input  logic      wb_rst_i,
  i2c_cmd_if.slave  cmd,
  i2c_wb_if.master  wbm
);
  state_t      state, state_nx;
  logic [1:0]  init_cnt, step, err_q;
  logic        rd_q, stopping;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, wdata_q, rdata_q, txr_byte;
  logic [19:0] tmo;
  logic        req, we, done, busy, tmo_hit, last_step;
  logic [2:0]  adr;
  logic [7:0]  wdat, rdata;

  i2c_wbm_port u_port (
    .clk(wb_clk_i), .rst(wb_rst_i), .req(req), .we(we), .adr(adr), .wdat(wdat),
    .done(done), .busy(busy), .rdata(rdata), .bus(wbm)
  );

  assign tmo_hit   = (tmo == POLL_TIMEOUT);
  assign last_step = (step == (rd_q ? 2'd3 : 2'd2));

  always_comb begin
    unique case (step)
      2'd0:    txr_byte = {dev_q, 1'b0};
      2'd1:    txr_byte = reg_q;
      default: txr_byte = rd_q ? {dev_q, 1'b1} : wdata_q;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_INIT;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    we       = 1'b0;
    adr      = 3'd0;
    wdat     = 8'h00;
    unique case (state)
      S_INIT: begin
        req  = 1'b1;
        we   = 1'b1;
        adr  = {1'b0, init_cnt};
        wdat = (init_cnt == 2'd0) ? PRESCALE[7:0] :
               (init_cnt == 2'd1) ? PRESCALE[15:8] : CTR_EN;
        if (done && init_cnt == 2'd2) state_nx = S_IDLE;
      end
      S_IDLE: if (cmd.cmd_valid) state_nx = S_TXR;
      S_TXR: begin
        req = 1'b1; we = 1'b1; adr = ADR_TXR; wdat = txr_byte;
        if (done) state_nx = S_CR;
      end
      S_CR: begin
        req = 1'b1; we = 1'b1; adr = ADR_CR; wdat = cr_cmd(step, rd_q);
        if (done) state_nx = S_POLL;
      end
      S_POLL: begin
        req = 1'b1;
        adr = ADR_CR;
        if (done) begin
          if (!rdata[SR_TIP]) begin
            if (stopping || rdata[SR_AL])               state_nx = S_RESP;
            else if (rdata[SR_RXACK] && step != 2'd3)   state_nx = S_STOP;
            else if (last_step)                         state_nx = rd_q ? S_RDRX : S_RESP;
            else if (rd_q && step == 2'd2)              state_nx = S_CR;
            else                                        state_nx = S_TXR;
          end
        end else if (tmo_hit && !busy) begin
          // never abandon an access in flight; the timeout acts between polls
          req      = 1'b0;
          state_nx = stopping ? S_RESP : S_STOP;
        end
      end
      S_STOP: begin
        req = 1'b1; we = 1'b1; adr = ADR_CR; wdat = CR_STO;
        if (done) state_nx = (err_q == ERR_TMO) ? S_RESP : S_POLL;
      end
      S_RDRX: begin
        req = 1'b1; adr = ADR_TXR;
        if (done) state_nx = S_RESP;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      init_cnt <= 2'd0; step <= 2'd0; err_q <= ERR_OK; rd_q <= 1'b0;
      stopping <= 1'b0; dev_q <= 7'd0; reg_q <= 8'h00; wdata_q <= 8'h00;
      rdata_q  <= 8'h00; tmo <= 20'd0;
    end else begin
      unique case (state)
        S_INIT: if (done) init_cnt <= init_cnt + 2'd1;
        S_IDLE: if (cmd.cmd_valid) begin
          rd_q <= cmd.cmd_rd; dev_q <= cmd.cmd_dev; reg_q <= cmd.cmd_reg;
          wdata_q <= cmd.cmd_wdata; step <= 2'd0; err_q <= ERR_OK; stopping <= 1'b0;
        end
        S_CR: if (done) tmo <= 20'd0;
        S_POLL: begin
          if (!tmo_hit) tmo <= tmo + 20'd1;
          if (done && !rdata[SR_TIP] && !stopping) begin
            if (rdata[SR_AL])                             err_q <= ERR_AL;
            else if (rdata[SR_RXACK] && step != 2'd3)     err_q <= ERR_NACK;
            else if (!last_step)                          step  <= step + 2'd1;
          end else if (!done && tmo_hit && !busy && !stopping) begin
            err_q <= ERR_TMO;
          end
        end
        S_STOP: if (done) begin
          tmo      <= 20'd0;
          stopping <= 1'b1;
        end
        S_RDRX: if (done) rdata_q <= rdata;
        default: ;
      endcase
    end
  end

  assign cmd.cmd_ready = (state == S_IDLE);
  assign cmd.rsp_valid = (state == S_RESP);
  assign cmd.rsp_rdata = rdata_q;
  assign cmd.rsp_err   = err_q;
endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Sequencer against a byte-level model of the I2C core plus a register slave at 0x50.
module tb_i2c_wb_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_cmd_if cif();
  i2c_wb_if  wif();

  i2c_wb_sequencer #(.PRESCALE(16'd99), .POLL_TIMEOUT(20'd500)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd(cif.slave), .wbm(wif.master)
  );

  int n_tests = 0, n_fail = 0, n_wr = 0;
  logic [10:0] wq[$];   // {adr, dat} of expected core writes
  logic [10:0] rq[$];   // {check_rdata, err, rdata}
  bit stretch = 0, al_inject = 0;

  // core + slave model
  logic [7:0] mem [256];
  logic [7:0] txr, rxr, ptr;
  logic [2:0] tip_cnt;
  logic stuck, rxack, al, present_q;
  logic [1:0] bidx;
  always @(posedge clk) begin
    if (rst) begin
      wif.ack <= 0; wif.rdat <= 0; tip_cnt <= 0; stuck <= 0; rxack <= 0; al <= 0;
      present_q <= 0; bidx <= 0; txr <= 0; rxr <= 0; ptr <= 0;
    end else begin
      wif.ack <= wif.stb && !wif.ack;
      if (tip_cnt != 0) tip_cnt <= tip_cnt - 3'd1;
      if (!stretch) stuck <= 0;
      if (wif.stb && !wif.ack) begin
        if (wif.we) begin
          if (wif.adr == 3'd3) txr <= wif.wdat;
          if (wif.adr == 3'd4 && wif.wdat[7:4] != 4'h0) begin
            tip_cnt <= 3'd4;
            if (stretch) stuck <= 1;
            al <= al_inject;
            if (wif.wdat[4]) begin
              if (wif.wdat[7]) begin
                present_q <= (txr[7:1] == 7'h50); rxack <= (txr[7:1] != 7'h50); bidx <= 0;
              end else begin
                rxack <= !present_q;
                if (present_q) begin
                  if (bidx == 0) ptr <= txr; else mem[ptr] <= txr;
                end
                bidx <= bidx + 2'd1;
              end
            end
            if (wif.wdat[5]) begin rxr <= mem[ptr]; rxack <= 1; end
          end
        end else begin
          wif.rdat <= (wif.adr == 3'd4) ? {rxack, 1'b0, al, 3'b000, (tip_cnt != 0) || stuck, 1'b0}
                    : (wif.adr == 3'd3) ? rxr : 8'h00;
        end
      end
    end
  end

  // write scoreboard
  always @(negedge clk) begin
    if (!rst && wif.stb && wif.ack && wif.we) begin
      logic [10:0] e;
      n_wr++;
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL wb_write: got adr=%0d dat=%h, required no write", wif.adr, wif.wdat);
      end else begin
        e = wq.pop_front();
        if ({wif.adr, wif.wdat} !== e) begin
          n_fail++;
          $display("FAIL wb_write: got adr=%0d dat=%h, required adr=%0d dat=%h",
                   wif.adr, wif.wdat, e[10:8], e[7:0]);
        end
      end
    end
  end

  // response scoreboard
  always @(negedge clk) begin
    if (!rst && cif.rsp_valid) begin
      logic [10:0] e;
      n_tests++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL rsp: got err=%0d, required no response", cif.rsp_err);
      end else begin
        e = rq.pop_front();
        if (cif.rsp_err !== e[9:8] || (e[10] && cif.rsp_rdata !== e[7:0])) begin
          n_fail++;
          $display("FAIL rsp: got err=%0d rdata=%h, required err=%0d rdata=%h",
                   cif.rsp_err, cif.rsp_rdata, e[9:8], e[7:0]);
        end
      end
    end
  end

  function automatic void push_w(input logic [2:0] a, input logic [7:0] d);
    wq.push_back({a, d});
  endfunction

  function automatic void push_init();
    push_w(0, 8'h63); push_w(1, 8'h00); push_w(2, 8'h80);
  endfunction

  task automatic send_cmd(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, output bit ok);
    int n;
    @(negedge clk);
    cif.cmd_valid = 1; cif.cmd_rd = rd; cif.cmd_dev = dev; cif.cmd_reg = rg; cif.cmd_wdata = wd;
    n = 0;
    while (!cif.cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    cif.cmd_valid = 0;
    n = 0;
    while (!cif.rsp_valid && n < 3000) begin @(negedge clk); n++; end
    ok = cif.rsp_valid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst = 1;
    #1;
    n_tests++;
    if ({wif.stb, wif.we, wif.adr, wif.wdat, cif.cmd_ready, cif.rsp_valid, cif.rsp_err, cif.rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stb=%b we=%b adr=%0d dat=%h rdy=%b rsp=%b err=%0d rd=%h, required all 0",
               wif.stb, wif.we, wif.adr, wif.wdat, cif.cmd_ready, cif.rsp_valid, cif.rsp_err, cif.rsp_rdata);
    end
    push_init();
    repeat (3) @(negedge clk);
    rst = 0;
    n = 0;
    while (!cif.cmd_ready && n < 100) begin @(negedge clk); n++; end
    n_tests++;
    if (cif.cmd_ready !== 1'b1 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL init_ready: got ready=%b pending_writes=%0d, required ready=1 pending=0", cif.cmd_ready, wq.size());
    end
  endtask

  task automatic test_write();
    bit ok;
    push_w(3, 8'hA0); push_w(4, 8'h90); push_w(3, 8'h12); push_w(4, 8'h10);
    push_w(3, 8'hA5); push_w(4, 8'h50);
    rq.push_back({1'b0, 2'd0, 8'h00});
    send_cmd(0, 7'h50, 8'h12, 8'hA5, ok);
    n_tests++;
    if (!ok || cif.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_rsp_pulse: got seen=%b after=%b, required seen=1 after=0", ok, cif.rsp_valid);
    end
    n_tests++;
    if (mem[8'h12] !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_slave_reg: got %h, required a5", mem[8'h12]);
    end
  endtask

  task automatic test_read();
    bit ok;
    push_w(3, 8'hA0); push_w(4, 8'h90); push_w(3, 8'h12); push_w(4, 8'h10);
    push_w(3, 8'hA1); push_w(4, 8'h90); push_w(4, 8'h68);
    rq.push_back({1'b1, 2'd0, 8'hA5});
    send_cmd(1, 7'h50, 8'h12, 8'h00, ok);
    n_tests++;
    if (!ok || wq.size() != 0) begin
      n_fail++;
      $display("FAIL read_done: got rsp=%b pending=%0d, required rsp=1 pending=0", ok, wq.size());
    end
  endtask

  task automatic test_nack();
    bit ok;
    push_w(3, 8'h66); push_w(4, 8'h90); push_w(4, 8'h40);
    rq.push_back({1'b0, 2'd1, 8'h00});
    send_cmd(0, 7'h33, 8'h01, 8'h02, ok);
    n_tests++;
    if (!ok || wq.size() != 0 || tip_cnt != 0) begin
      n_fail++;
      $display("FAIL nack_stop: got rsp=%b pending=%0d tip=%0d, required 1/0/0", ok, wq.size(), tip_cnt);
    end
  endtask

  task automatic test_al();
    bit ok;
    al_inject = 1;
    push_w(3, 8'hA0); push_w(4, 8'h90);
    rq.push_back({1'b0, 2'd2, 8'h00});
    send_cmd(0, 7'h50, 8'h20, 8'h01, ok);
    // absent device too: AL must win over the simultaneous NACK, no STOP
    push_w(3, 8'h66); push_w(4, 8'h90);
    rq.push_back({1'b0, 2'd2, 8'h00});
    send_cmd(0, 7'h33, 8'h20, 8'h01, ok);
    al_inject = 0;
    n_tests++;
    if (!ok || wq.size() != 0) begin
      n_fail++;
      $display("FAIL al_priority: got rsp=%b pending=%0d, required rsp=1 pending=0", ok, wq.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t0, dt;
    stretch = 1;
    push_w(3, 8'hA0); push_w(4, 8'h90); push_w(4, 8'h40);
    rq.push_back({1'b0, 2'd3, 8'h00});
    t0 = $time / 10;
    send_cmd(0, 7'h50, 8'h40, 8'h55, ok);
    dt = $time / 10 - t0;
    stretch = 0;
    n_tests++;
    if (!ok || dt < 500 || dt > 560) begin
      n_fail++;
      $display("FAIL timeout_latency: got rsp=%b cycles=%0d, required rsp=1 cycles 500..560", ok, dt);
    end
  endtask

  task automatic test_back_to_back();
    int n, seen;
    push_w(3, 8'hA0); push_w(4, 8'h90); push_w(3, 8'h34); push_w(4, 8'h10);
    push_w(3, 8'h5A); push_w(4, 8'h50);
    push_w(3, 8'hA0); push_w(4, 8'h90); push_w(3, 8'h34); push_w(4, 8'h10);
    push_w(3, 8'hA1); push_w(4, 8'h90); push_w(4, 8'h68);
    rq.push_back({1'b0, 2'd0, 8'h00});
    rq.push_back({1'b1, 2'd0, 8'h5A});
    @(negedge clk);
    cif.cmd_valid = 1; cif.cmd_rd = 0; cif.cmd_dev = 7'h50; cif.cmd_reg = 8'h34; cif.cmd_wdata = 8'h5A;
    n = 0;
    while (!cif.cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    n_tests++;
    if (cif.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_drop: got %b, required 0", cif.cmd_ready);
    end
    cif.cmd_rd = 1; cif.cmd_wdata = 8'hFF;
    seen = 0; n = 0;
    while (seen < 2 && n < 3000) begin
      if (cif.rsp_valid) seen++;
      if (seen < 2) begin @(negedge clk); n++; end
    end
    cif.cmd_valid = 0;
    @(negedge clk);
    n_tests++;
    if (seen != 2 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back: got rsps=%0d pending=%0d, required 2/0", seen, wq.size());
    end
  endtask

  task automatic test_reset_mid();
    int n, base;
    base = n_wr;
    push_w(3, 8'hA0); push_w(4, 8'h90); push_w(3, 8'h77); push_w(4, 8'h10);
    push_w(3, 8'h11); push_w(4, 8'h50);
    @(negedge clk);
    cif.cmd_valid = 1; cif.cmd_rd = 0; cif.cmd_dev = 7'h50; cif.cmd_reg = 8'h77; cif.cmd_wdata = 8'h11;
    @(negedge clk);
    cif.cmd_valid = 0;
    n = 0;
    while ((n_wr < base + 4 || !wif.stb) && n < 500) begin @(negedge clk); n++; end
    rst = 1;
    #1;
    n_tests++;
    if ({wif.stb, wif.we, wif.adr, wif.wdat, cif.cmd_ready, cif.rsp_valid} !== '0 || n >= 500) begin
      n_fail++;
      $display("FAIL reset_mid: got stb=%b we=%b adr=%0d dat=%h rdy=%b rsp=%b wait=%0d, required all 0",
               wif.stb, wif.we, wif.adr, wif.wdat, cif.cmd_ready, cif.rsp_valid, n);
    end
    wq.delete();
    rq.delete();
    push_init();
    repeat (2) @(negedge clk);
    rst = 0;
    n = 0;
    while (!cif.cmd_ready && n < 100) begin @(negedge clk); n++; end
    n_tests++;
    if (cif.cmd_ready !== 1'b1 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL reinit: got ready=%b pending=%0d, required 1/0", cif.cmd_ready, wq.size());
    end
  endtask

  initial begin
    rst = 1;
    cif.cmd_valid = 0; cif.cmd_rd = 0; cif.cmd_dev = 0; cif.cmd_reg = 0; cif.cmd_wdata = 0;
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_al();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    n_tests++;
    if (rq.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_leftover: got %0d pending responses, required 0", rq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
